// File: rtl/io_cmd_pkg.sv
// Shared widths, helpers and the response-entry type for the IO command dispatcher.
package io_cmd_pkg;

    localparam int TAG_W         = 4;
    localparam int RESP_DATA_MAX = 64;

    function automatic int calcWpc(input int dataBits, input int portBytes);
        return (portBytes * 8) / dataBits;
    endfunction

    // Select fields never collapse to zero width, even for a single word or channel.
    function automatic int calcSelW(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int WPC        = calcWpc(16, 4);
    localparam int WORD_SEL_W = calcSelW(WPC);
    localparam int CHAN_SEL_W = calcSelW(4);

    typedef logic [TAG_W-1:0] regTag_t;

    // Data is held zero-extended so one type serves any system word width up to 64 bits.
    typedef struct packed {
        regTag_t                  tag;
        logic [RESP_DATA_MAX-1:0] data;
    } respEntry_t;

endpackage

// File: rtl/io_cmd_fifo.sv
// Single-clock FIFO with registered pointers; head is visible the cycle after the first push.
// Push is ignored when full and pop is ignored when empty, so callers gate with full/empty.
module io_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
)(
    input  logic             sys_clk,
    input  logic             async_rst_n,
    input  logic             pushEn,
    input  logic [WIDTH-1:0] pushDat,
    input  logic             popEn,
    output logic [WIDTH-1:0] headDat,
    output logic             empty,
    output logic             full
);

    localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wrPtr;
    logic [PtrW-1:0]  rdPtr;
    logic [PtrW:0]    count;
    logic             doPush;
    logic             doPop;

    assign doPush  = pushEn & ~full;
    assign doPop   = popEn & ~empty;
    assign empty   = (count == '0);
    assign full    = (count == (PtrW+1)'(DEPTH));
    assign headDat = mem[rdPtr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge sys_clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PtrW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PtrW'(1);
            end
            if (doPush && !doPop) begin
                count <= count + (PtrW+1)'(1);
            end else if (doPop && !doPush) begin
                count <= count - (PtrW+1)'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushDat;
        end
    end

endmodule

// File: rtl/io_command_dispatcher.sv
// Routes stores into per-channel FIFOs (head visible next cycle), serves loads from channel buffers
// with zero latency, and arbitrates captured port responses round-robin ahead of loads onto writeback.
module io_command_dispatcher
    import io_cmd_pkg::*;
#(
    parameter int DATABITWIDTH  = 16,
    parameter int PORTBYTEWIDTH = 4,
    parameter int CHANNELS      = 4,
    parameter int FIFODEPTH     = 4
)(
    input  logic                                          sys_clk,
    input  logic                                          async_rst_n,
    input  logic                                          clk_en,
    input  logic                                          CommandACK,
    output logic                                          CommandREQ,
    input  logic                                          CommandLoadEn,
    input  logic                                          CommandStoreEn,
    input  logic [DATABITWIDTH-1:0]                       CommandAddressIn,
    input  logic [TAG_W-1:0]                              CommandDestReg,
    input  logic [DATABITWIDTH-1:0]                       CommandDataIn,
    output logic                                          WritebackACK,
    input  logic                                          WritebackREQ,
    output logic [TAG_W-1:0]                              WritebackDestReg,
    output logic [DATABITWIDTH-1:0]                       WritebackDataOut,
    output logic [CHANNELS-1:0]                           IOOutACK,
    input  logic [CHANNELS-1:0]                           IOOutREQ,
    output logic [CHANNELS-1:0][TAG_W-1:0]                IODestRegOut,
    output logic [CHANNELS-1:0][DATABITWIDTH-1:0]         IODataOut,
    input  logic [CHANNELS-1:0]                           IOInACK,
    output logic [CHANNELS-1:0]                           IOInREQ,
    input  logic [CHANNELS-1:0]                           IORegResponseFlag,
    input  logic [CHANNELS-1:0][TAG_W-1:0]                IODestRegIn,
    input  logic [CHANNELS-1:0][PORTBYTEWIDTH*8-1:0]      IODataIn
);

    localparam int ChWords   = calcWpc(DATABITWIDTH, PORTBYTEWIDTH);
    localparam int WordShift = $clog2(ChWords);
    localparam int WordSelW  = calcSelW(ChWords);
    localparam int ChanSelW  = calcSelW(CHANNELS);
    localparam int EntryW    = TAG_W + DATABITWIDTH;

    logic                                             runFlag;
    logic [ChanSelW-1:0]                              selChan;
    logic [WordSelW-1:0]                              selWord;
    logic                                             isStore;
    logic                                             isLoad;
    logic                                             storeTake;
    logic                                             respTake;
    logic                                             respPending;
    logic [CHANNELS-1:0]                              fifoPush;
    logic [CHANNELS-1:0]                              fifoPop;
    logic [CHANNELS-1:0]                              fifoEmpty;
    logic [CHANNELS-1:0]                              fifoFull;
    logic [CHANNELS-1:0][EntryW-1:0]                  fifoHead;
    logic [CHANNELS-1:0][ChWords-1:0][DATABITWIDTH-1:0] chanBuf;
    logic [CHANNELS-1:0]                              inTake;
    logic [CHANNELS-1:0]                              respValid;
    respEntry_t                                       respReg [CHANNELS];
    logic [ChanSelW-1:0]                              rrPtr;
    logic [ChanSelW-1:0]                              rrCand;
    logic [ChanSelW-1:0]                              rrWinner;
    logic                                             rrFound;

    // Low address bits pick the word inside a port, the next bits pick the channel.
    assign selChan = ChanSelW'(CommandAddressIn >> WordShift);
    assign selWord = WordSelW'(CommandAddressIn) & WordSelW'(ChWords - 1);

    assign isStore     = CommandStoreEn;
    assign isLoad      = CommandLoadEn & ~CommandStoreEn;
    assign respPending = |respValid;

    // runFlag keeps every ready/valid low from reset until the first enabled edge after release.
    always_comb begin
        CommandREQ = 1'b0;
        if (runFlag) begin
            if (isStore) begin
                CommandREQ = ~fifoFull[selChan];
            end else if (isLoad) begin
                CommandREQ = WritebackREQ & ~respPending;
            end else begin
                CommandREQ = 1'b1;
            end
        end
    end

    assign storeTake = CommandACK & CommandREQ & isStore & clk_en;
    assign IOInREQ   = {CHANNELS{runFlag}} & ~respValid;
    assign inTake    = IOInACK & IOInREQ & {CHANNELS{clk_en}};
    assign IOOutACK  = ~fifoEmpty;
    assign fifoPop   = IOOutACK & IOOutREQ & {CHANNELS{clk_en}};

    for (genvar c = 0; c < CHANNELS; c++) begin : gChan
        assign fifoPush[c]     = storeTake & (selChan == ChanSelW'(c));
        assign IODestRegOut[c] = fifoHead[c][EntryW-1 -: TAG_W];
        assign IODataOut[c]    = fifoHead[c][DATABITWIDTH-1:0];

        io_cmd_fifo #(
            .WIDTH (EntryW),
            .DEPTH (FIFODEPTH)
        ) uFifo (
            .sys_clk     (sys_clk),
            .async_rst_n (async_rst_n),
            .pushEn      (fifoPush[c]),
            .pushDat     ({CommandDestReg, CommandDataIn}),
            .popEn       (fifoPop[c]),
            .headDat     (fifoHead[c]),
            .empty       (fifoEmpty[c]),
            .full        (fifoFull[c])
        );
    end

    // First pending response at or after rrPtr wins.
    always_comb begin
        rrFound  = 1'b0;
        rrWinner = rrPtr;
        rrCand   = rrPtr;
        for (int k = 0; k < CHANNELS; k++) begin
            rrCand = rrPtr + ChanSelW'(k);
            if (!rrFound && respValid[rrCand]) begin
                rrFound  = 1'b1;
                rrWinner = rrCand;
            end
        end
    end

    // Buffer reads are combinational, so a same-cycle port write still returns the old word.
    always_comb begin
        WritebackACK     = 1'b0;
        WritebackDestReg = CommandDestReg;
        WritebackDataOut = chanBuf[selChan][selWord];
        if (runFlag) begin
            if (respPending) begin
                WritebackACK     = 1'b1;
                WritebackDestReg = respReg[rrWinner].tag;
                WritebackDataOut = DATABITWIDTH'(respReg[rrWinner].data);
            end else begin
                WritebackACK = CommandACK & isLoad;
            end
        end
    end

    assign respTake = respPending & WritebackACK & WritebackREQ & clk_en;

    always_ff @(posedge sys_clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            runFlag   <= 1'b0;
            rrPtr     <= '0;
            respValid <= '0;
            chanBuf   <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                respReg[c] <= '0;
            end
        end else if (clk_en) begin
            runFlag <= 1'b1;
            for (int c = 0; c < CHANNELS; c++) begin
                if (inTake[c]) begin
                    chanBuf[c] <= IODataIn[c];
                    if (IORegResponseFlag[c]) begin
                        respValid[c] <= 1'b1;
                        respReg[c]   <= '{tag:  IODestRegIn[c],
                                          data: RESP_DATA_MAX'(IODataIn[c][DATABITWIDTH-1:0])};
                    end
                end
            end
            // A capturing channel is never the winner: its ready was low while it held a response.
            if (respTake) begin
                respValid[rrWinner] <= 1'b0;
                rrPtr               <= rrWinner + ChanSelW'(1);
            end
        end
    end

endmodule

// File: tb/tb_io_command_dispatcher.sv
// Directed and randomized bench for io_command_dispatcher against a queue-based behavioural model.
module tb_io_command_dispatcher;
    import io_cmd_pkg::*;

    localparam int DBW = 16;
    localparam int PBW = 4;
    localparam int CH  = 4;
    localparam int FD  = 4;
    localparam int PW  = PBW * 8;
    localparam int WW  = WPC;

    logic                    sys_clk;
    logic                    async_rst_n;
    logic                    clk_en;
    logic                    CommandACK;
    logic                    CommandREQ;
    logic                    CommandLoadEn;
    logic                    CommandStoreEn;
    logic [DBW-1:0]          CommandAddressIn;
    logic [3:0]              CommandDestReg;
    logic [DBW-1:0]          CommandDataIn;
    logic                    WritebackACK;
    logic                    WritebackREQ;
    logic [3:0]              WritebackDestReg;
    logic [DBW-1:0]          WritebackDataOut;
    logic [CH-1:0]           IOOutACK;
    logic [CH-1:0]           IOOutREQ;
    logic [CH-1:0][3:0]      IODestRegOut;
    logic [CH-1:0][DBW-1:0]  IODataOut;
    logic [CH-1:0]           IOInACK;
    logic [CH-1:0]           IOInREQ;
    logic [CH-1:0]           IORegResponseFlag;
    logic [CH-1:0][3:0]      IODestRegIn;
    logic [CH-1:0][PW-1:0]   IODataIn;

    io_command_dispatcher #(
        .DATABITWIDTH (DBW),
        .PORTBYTEWIDTH(PBW),
        .CHANNELS     (CH),
        .FIFODEPTH    (FD)
    ) dut (
        .sys_clk          (sys_clk),
        .async_rst_n      (async_rst_n),
        .clk_en           (clk_en),
        .CommandACK       (CommandACK),
        .CommandREQ       (CommandREQ),
        .CommandLoadEn    (CommandLoadEn),
        .CommandStoreEn   (CommandStoreEn),
        .CommandAddressIn (CommandAddressIn),
        .CommandDestReg   (CommandDestReg),
        .CommandDataIn    (CommandDataIn),
        .WritebackACK     (WritebackACK),
        .WritebackREQ     (WritebackREQ),
        .WritebackDestReg (WritebackDestReg),
        .WritebackDataOut (WritebackDataOut),
        .IOOutACK         (IOOutACK),
        .IOOutREQ         (IOOutREQ),
        .IODestRegOut     (IODestRegOut),
        .IODataOut        (IODataOut),
        .IOInACK          (IOInACK),
        .IOInREQ          (IOInREQ),
        .IORegResponseFlag(IORegResponseFlag),
        .IODestRegIn      (IODestRegIn),
        .IODataIn         (IODataIn)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: FIFOs as queues of {tag,data}, port buffers, one-entry response slots.
    logic [19:0]   fq [CH][$];
    logic [PW-1:0] mBuf  [CH];
    bit            mPend [CH];
    logic [3:0]    mTag  [CH];
    logic [15:0]   mData [CH];
    int            rr;
    bit            running;

    task automatic modelReset();
        for (int c = 0; c < CH; c++) begin
            fq[c].delete();
            mBuf[c]  = '0;
            mPend[c] = 0;
            mTag[c]  = '0;
            mData[c] = '0;
        end
        rr      = 0;
        running = 0;
    endtask

    task automatic checkCycle();
        int          ch;
        int          w;
        int          win;
        int          cc;
        bit          anyP;
        bit          isSt;
        bit          isLd;
        bit          expReq;
        bit          expWb;
        bit          expInReq [CH];
        logic [3:0]  eTag;
        logic [15:0] eData;
        logic [19:0] hd;

        ch   = (int'(CommandAddressIn) / WW) % CH;
        w    = int'(CommandAddressIn) % WW;
        isSt = CommandStoreEn;
        isLd = CommandLoadEn && !CommandStoreEn;
        win  = -1;
        for (int k = 0; k < CH; k++) begin
            cc = (rr + k) % CH;
            if (mPend[cc] && win < 0) win = cc;
        end
        anyP = (win >= 0);

        if (!running)  expReq = 0;
        else if (isSt) expReq = (fq[ch].size() < FD);
        else if (isLd) expReq = WritebackREQ && !anyP;
        else           expReq = 1;
        expWb = running && (anyP || (CommandACK && isLd));

        chk("cmd_req", CommandREQ, expReq);
        chk("wb_ack", WritebackACK, expWb);
        if (expWb) begin
            if (anyP) begin
                eTag  = mTag[win];
                eData = mData[win];
            end else begin
                eTag  = CommandDestReg;
                eData = 16'(mBuf[ch] >> (DBW * w));
            end
            chk("wb_tag", WritebackDestReg, eTag);
            chk("wb_data", WritebackDataOut, eData);
        end
        for (int c = 0; c < CH; c++) begin
            expInReq[c] = running && !mPend[c];
            chk("io_in_req", IOInREQ[c], expInReq[c]);
            chk("io_out_ack", IOOutACK[c], fq[c].size() != 0);
            if (fq[c].size() != 0) begin
                hd = fq[c][0];
                chk("io_out_tag", IODestRegOut[c], hd[19:16]);
                chk("io_out_data", IODataOut[c], hd[15:0]);
            end
        end

        if (clk_en) begin
            for (int c = 0; c < CH; c++) begin
                if (fq[c].size() != 0 && IOOutREQ[c]) void'(fq[c].pop_front());
            end
            if (CommandACK && expReq && isSt) fq[ch].push_back({CommandDestReg, CommandDataIn});
            for (int c = 0; c < CH; c++) begin
                if (IOInACK[c] && expInReq[c]) begin
                    mBuf[c] = IODataIn[c];
                    if (IORegResponseFlag[c]) begin
                        mPend[c] = 1;
                        mTag[c]  = IODestRegIn[c];
                        mData[c] = IODataIn[c][15:0];
                    end
                end
            end
            if (running && anyP && WritebackREQ) begin
                mPend[win] = 0;
                rr = (win + 1) % CH;
            end
            running = 1;
        end
    endtask

    always @(negedge sys_clk) begin
        if (!async_rst_n) begin
            modelReset();
            chk("rst_cmd_req", CommandREQ, 0);
            chk("rst_wb_ack", WritebackACK, 0);
            chk("rst_out_ack", IOOutACK, 0);
            chk("rst_in_req", IOInREQ, 0);
        end else begin
            checkCycle();
        end
    end

    task automatic idleInputs();
        CommandACK        = 0;
        CommandLoadEn     = 0;
        CommandStoreEn    = 0;
        CommandAddressIn  = '0;
        CommandDestReg    = '0;
        CommandDataIn     = '0;
        WritebackREQ      = 1;
        IOOutREQ          = '0;
        IOInACK           = '0;
        IORegResponseFlag = '0;
        IODestRegIn       = '0;
        IODataIn          = '0;
        clk_en            = 1;
    endtask

    task automatic nextCycle();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        idleInputs();
        async_rst_n = 0;
        #2;
        chk("lit_reset_cmd_req", CommandREQ, 0);
        chk("lit_reset_wb_ack", WritebackACK, 0);
        chk("lit_reset_out_ack", IOOutACK, 0);
        chk("lit_reset_in_req", IOInREQ, 0);
        nextCycle();
        nextCycle();
        async_rst_n = 1;
        nextCycle();
        #2 chk("lit_idle_cmd_req", CommandREQ, 1);

        // Store to channel 2, visible next cycle.
        CommandACK = 1; CommandStoreEn = 1; CommandAddressIn = 16'h0004;
        CommandDataIn = 16'hBEEF; CommandDestReg = 4'd5;
        chk("lit_store_req", CommandREQ, 1);
        nextCycle();
        idleInputs();
        #1;
        chk("lit_store_ack2", IOOutACK[2], 1);
        chk("lit_store_data2", IODataOut[2], 16'hBEEF);
        chk("lit_store_tag2", IODestRegOut[2], 4'd5);
        IOOutREQ[2] = 1;
        nextCycle();
        idleInputs();
        #1 chk("lit_store_popped", IOOutACK[2], 0);

        // Fill channel 1, fifth store stalls until one pop.
        for (int i = 0; i < 4; i++) begin
            CommandACK = 1; CommandStoreEn = 1; CommandAddressIn = 16'h0002;
            CommandDataIn = 16'(16'h1000 + i); CommandDestReg = 4'(i);
            nextCycle();
        end
        CommandDataIn = 16'h1004; CommandDestReg = 4'd4;
        #1 chk("lit_full_req", CommandREQ, 0);
        IOOutREQ[1] = 1;
        nextCycle();
        IOOutREQ[1] = 0;
        #1 chk("lit_after_pop_req", CommandREQ, 1);
        nextCycle();
        idleInputs();
        #1 chk("lit_head_after_pop", IODataOut[1], 16'h1001);
        IOOutREQ[1] = 1;
        repeat (4) nextCycle();
        idleInputs();

        // Port data without response flag, then two loads.
        IOInACK[3] = 1; IODataIn[3] = 32'h12345678;
        #1 chk("lit_in_req3", IOInREQ[3], 1);
        nextCycle();
        idleInputs();
        CommandACK = 1; CommandLoadEn = 1; CommandAddressIn = 16'h0007; CommandDestReg = 4'd2;
        #1;
        chk("lit_load_hi_ack", WritebackACK, 1);
        chk("lit_load_hi_data", WritebackDataOut, 16'h1234);
        chk("lit_load_hi_req", CommandREQ, 1);
        nextCycle();
        CommandAddressIn = 16'h0006;
        #1 chk("lit_load_lo_data", WritebackDataOut, 16'h5678);
        nextCycle();
        idleInputs();
        #1 chk("lit_no_extra_wb", WritebackACK, 0);

        // Simultaneous responses on channels 0 and 2 with a load waiting.
        IOInACK = 4'b0101; IORegResponseFlag = 4'b0101;
        IODestRegIn[0] = 4'd7; IODestRegIn[2] = 4'd9;
        IODataIn[0] = 32'hCAFE0A0A; IODataIn[2] = 32'h00000B0B;
        nextCycle();
        idleInputs();
        CommandACK = 1; CommandLoadEn = 1; CommandAddressIn = 16'h0000; CommandDestReg = 4'd3;
        #1;
        chk("lit_resp1_tag", WritebackDestReg, 4'd7);
        chk("lit_resp1_data", WritebackDataOut, 16'h0A0A);
        chk("lit_resp1_cmd_req", CommandREQ, 0);
        nextCycle();
        #1;
        chk("lit_resp2_tag", WritebackDestReg, 4'd9);
        chk("lit_resp2_data", WritebackDataOut, 16'h0B0B);
        chk("lit_resp2_cmd_req", CommandREQ, 0);
        nextCycle();
        #1;
        chk("lit_load_resume_req", CommandREQ, 1);
        chk("lit_load_resume_tag", WritebackDestReg, 4'd3);
        chk("lit_load_resume_data", WritebackDataOut, 16'h0A0A);
        nextCycle();
        idleInputs();

        // Asynchronous reset with two entries queued.
        CommandACK = 1; CommandStoreEn = 1; CommandAddressIn = 16'h0000; CommandDataIn = 16'h1111;
        nextCycle();
        CommandDataIn = 16'h2222;
        nextCycle();
        idleInputs();
        chk("lit_pre_rst_ack", IOOutACK[0], 1);
        async_rst_n = 0;
        #1;
        chk("lit_async_out_ack", IOOutACK, 0);
        chk("lit_async_cmd_req", CommandREQ, 0);
        chk("lit_async_in_req", IOInREQ, 0);
        nextCycle();
        async_rst_n = 1;
        nextCycle();
        CommandACK = 1; CommandLoadEn = 1; CommandAddressIn = 16'h0006; CommandDestReg = 4'd1;
        #1;
        chk("lit_post_rst_out_ack", IOOutACK, 0);
        chk("lit_post_rst_load_ack", WritebackACK, 1);
        chk("lit_post_rst_load_data", WritebackDataOut, 16'h0000);
        nextCycle();
        idleInputs();

        // Randomized traffic, with one mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            clk_en           = ($urandom_range(0, 9) != 0);
            CommandACK       = ($urandom_range(0, 9) < 6);
            CommandStoreEn   = ($urandom_range(0, 2) == 0);
            CommandLoadEn    = ($urandom_range(0, 1) == 0);
            CommandAddressIn = 16'($urandom);
            CommandDestReg   = 4'($urandom);
            CommandDataIn    = 16'($urandom);
            WritebackREQ     = ($urandom_range(0, 9) < 7);
            for (int c = 0; c < CH; c++) begin
                IOOutREQ[c]          = ($urandom_range(0, 1) == 0);
                IOInACK[c]           = ($urandom_range(0, 9) < 4);
                IORegResponseFlag[c] = ($urandom_range(0, 9) < 3);
                IODestRegIn[c]       = 4'($urandom);
                IODataIn[c]          = 32'($urandom);
            end
            if (i == 1500) async_rst_n = 0;
            if (i == 1503) async_rst_n = 1;
            nextCycle();
        end
        idleInputs();
        nextCycle();
        nextCycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
